alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares one arithmetic_logic_system instance between two requesters (port 0: main execute datapath; port 1: address/branch-compare unit). Per requester: valid/ready operation request, one-cycle result pulse. Owns all ALU input pins (A, B, Imm, ALUsrc, ALUop) and samples ALUout/AltB after a fixed settle latency. Round-robin arbitration, one operation in flight at a time.

Parameters:
WIDTH, 16, operand/result width (matches ALU datapath)
ALU_LAT, 1, cycles ALU inputs are held stable before ALUout/AltB is sampled; legal 1..7

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle when valid&ready
req0_A, req0_B, req0_Imm  input  WIDTH each  requester 0 operands
req0_ALUsrc  input  1  requester 0 B/Imm select
req0_ALUop  input  3  requester 0 ALU operation
rsp0_valid  output  1  one-cycle result pulse to requester 0
rsp0_ALUout  output  WIDTH  result for requester 0
rsp0_AltB  output  1  A<B flag for requester 0
req1_*, rsp1_*  same set for requester 1
alu_A, alu_B, alu_Imm  output  WIDTH each  to ALU
alu_ALUsrc  output  1  to ALU
alu_ALUop  output  3  to ALU
alu_ALUout  input  WIDTH  from ALU
alu_AltB  input  1  from ALU
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, prio pointer=0, all req*_ready=0, rsp*_valid=0, rsp* data=0, alu_* outputs=0, busy=0, settle counter=0.
- States: IDLE, HOLD, RESP.
- IDLE: ready asserted combinationally to exactly one requester:
  - only one valid: that one.
  - both valid: requester named by prio pointer.
  - none valid: no ready.
- Acceptance edge (valid&ready):
  - register operands, ALUsrc, ALUop and owner id onto alu_* outputs.
  - prio pointer := ~owner.
  - counter := ALU_LAT-1; go to HOLD.
- HOLD: alu_* stable; counter decrements each cycle. At counter==0, capture alu_ALUout/alu_AltB into owner's rsp registers; go to RESP.
- RESP: rsp<owner>_valid=1 for exactly one cycle; other rsp_valid=0; ready=0 to both; next state IDLE.
- Latency: accept at edge N -> ALU driven from cycle N+1 -> rsp_valid high in cycle N+1+ALU_LAT. Max throughput: one op per ALU_LAT+2 cycles.
- Outputs after completion:
  - alu_* hold last operands after RESP (no toggling while idle).
  - rsp data holds until next capture for that port; non-owner rsp data unchanged.
- No response backpressure: requester must take rsp in its pulse cycle.
- Requester may change or drop valid at any time; only sampled at acceptance edge.
- Non-granted requester waits, ready=0; no starvation: after every grant the other side wins the next contention.
- Reset mid-operation (HOLD or RESP): operation aborted; no rsp pulse; all state/outputs to reset values next edge.
- ALUop/ALUsrc passed through unchanged; no decoding; results not modified.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- defined: requester 0 always wins contention; prio pointer removed; requester 1 granted only when req0_valid=0 in IDLE.
- undefined: round-robin as above.
- All other timing identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with both valids high -> all ready/rsp_valid/busy 0, alu_* = 0; first grant after release goes to requester 0.
- Single op, ALU_LAT=1: req0 A=16'hFFF6, B=16'hFFF6, ALUop=0, ALUsrc=0 accepted at edge N -> alu_A=FFF6 from N+1; rsp0_valid only in cycle N+2; rsp0_ALUout=16'hFFF6 (AND); rsp1_valid stays 0.
- Contention round-robin: both valid continuously, 4 ops -> grants alternate 0,1,0,1; each rsp pulse on matching port; accepts spaced ALU_LAT+2 cycles apart.
- AltB path: req1 A=3, B=5, set-less-than op -> rsp1_AltB=1; then A=5, B=3 -> rsp1_AltB=0; rsp0 data unchanged.
- Reset mid-HOLD with ALU_LAT=4: assert reset 2 cycles after accept -> no rsp pulse ever; busy=0 next edge; next request served normally.
- ALU_ARB_FIXED_PRIO_EN defined, both valid for 3 ops -> all 3 grants to requester 0; drop req0_valid -> requester 1 granted next IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [WIDTH-1:0] req0_Imm,
    input  logic             req0_ALUsrc,
    input  logic [2:0]       req0_ALUop,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_ALUout,
    output logic             rsp0_AltB,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [WIDTH-1:0] req1_Imm,
    input  logic             req1_ALUsrc,
    input  logic [2:0]       req1_ALUop,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_ALUout,
    output logic             rsp1_AltB,

    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [WIDTH-1:0] alu_Imm,
    output logic             alu_ALUsrc,
    output logic [2:0]       alu_ALUop,
    input  logic [WIDTH-1:0] alu_ALUout,
    input  logic             alu_AltB,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RESP
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic [2:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       capture;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic       prio;
`endif

    // Grants are gated by reset so nothing is accepted while it is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
`else
            if (req0_valid && req1_valid) begin
                grant0 = !prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`endif
        end
    end

    assign accept  = grant0 | grant1;
    assign capture = (state == HOLD) && (cnt == 3'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = HOLD;
            HOLD:    if (cnt == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner <= grant1;
                cnt   <= CNT_INIT;
            end else if (state == HOLD && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // The side that just won loses the next contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= grant0;
        end
    end
`endif

    // ALU pins only change on acceptance, so they stay quiet while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_Imm    <= '0;
            alu_ALUsrc <= 1'b0;
            alu_ALUop  <= 3'd0;
        end else if (accept) begin
            alu_A      <= grant1 ? req1_A      : req0_A;
            alu_B      <= grant1 ? req1_B      : req0_B;
            alu_Imm    <= grant1 ? req1_Imm    : req0_Imm;
            alu_ALUsrc <= grant1 ? req1_ALUsrc : req0_ALUsrc;
            alu_ALUop  <= grant1 ? req1_ALUop  : req0_ALUop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_ALUout <= '0;
            rsp0_AltB   <= 1'b0;
            rsp1_ALUout <= '0;
            rsp1_AltB   <= 1'b0;
        end else if (capture) begin
            if (owner) begin
                rsp1_ALUout <= alu_ALUout;
                rsp1_AltB   <= alu_AltB;
            end else begin
                rsp0_ALUout <= alu_ALUout;
                rsp0_AltB   <= alu_AltB;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state == RESP) && !owner && !reset;
    assign rsp1_valid = (state == RESP) && owner && !reset;
    assign busy       = (state != IDLE);

endmodule
